// File: rtl/cswap_ladder_pkg.sv
// Shared X25519 definitions for the conditional-swap ladder block.
package cswap_ladder_pkg;

    localparam int unsigned X25519_WID = 256;
    localparam int unsigned LANE_X     = 0;
    localparam int unsigned LANE_Z     = 1;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_LADDER = 1'b1
    } mode_e;

endpackage

// File: rtl/cswap_ladder_lane.sv
// One WID-bit lane of the constant-time masked-xor swap, staged LAT deep.
module cswap_lane #(
    parameter int unsigned WID  = 256,
    parameter int unsigned LAT  = 2,
    parameter bit          INIT = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           ld,
    input  logic           s,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    output logic [WID-1:0] aswap,
    output logic [WID-1:0] bswap
);

    localparam logic [WID-1:0] FILL = {WID{INIT}};

    generate
        if (LAT == 1) begin : g_single
            logic [WID-1:0] ra, rb, d;

            assign d = (a ^ b) & {WID{s}};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ra <= FILL;
                    rb <= FILL;
                end else if (ld && en) begin
                    ra <= a ^ d;
                    rb <= b ^ d;
                end
            end

            assign aswap = ra;
            assign bswap = rb;
        end else begin : g_multi
            logic [WID-1:0] ra [LAT];
            logic [WID-1:0] rb [LAT];
            logic [WID-1:0] rd;

            // s arrives aligned with the last-but-one stage, where d is formed
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned k = 0; k < LAT; k++) begin
                        ra[k] <= FILL;
                        rb[k] <= FILL;
                    end
                    rd <= FILL;
                end else begin
                    if (ld) begin
                        ra[0] <= a;
                        rb[0] <= b;
                    end
                    if (en) begin
                        for (int unsigned k = 1; k < LAT; k++) begin
                            ra[k] <= ra[k-1];
                            rb[k] <= rb[k-1];
                        end
                        rd <= (ra[LAT-2] ^ rb[LAT-2]) & {WID{s}};
                    end
                end
            end

            assign aswap = ra[LAT-1] ^ rd;
            assign bswap = rb[LAT-1] ^ rd;
        end
    endgenerate

endmodule

// File: rtl/cswap_ladder.sv
// Multi-lane constant-time conditional swap with ladder swap state and elastic staging.
module cswap_ladder
    import cswap_ladder_pkg::*;
#(
    parameter int unsigned WID   = X25519_WID,
    parameter int unsigned NLANE = 2,
    parameter int unsigned LAT   = 2,
    parameter bit          INIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic                 mode,
    input  logic                 swap,
    input  logic                 kbit,
    input  logic                 ldr_clr,
    input  logic [NLANE*WID-1:0] a,
    input  logic [NLANE*WID-1:0] b,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [NLANE*WID-1:0] aswap,
    output logic [NLANE*WID-1:0] bswap,
    output logic                 swap_eff,
    output logic                 ldr_state
);

    logic           stall, en, accept, prev, s_new, s_lane;
    logic           ldr_q;
    logic [LAT-1:0] vld;
    logic [LAT-1:0] s_q;

    assign stall  = vld[LAT-1] & ~out_rdy;
    assign en     = ~stall;
    assign in_rdy = en;
    assign accept = in_vld & en;

    assign prev  = ldr_clr ? 1'b0 : ldr_q;
    assign s_new = (mode == MODE_LADDER) ? (kbit ^ prev) : swap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            s_q <= {LAT{INIT}};
        end else if (en) begin
            vld[0] <= accept;
            if (accept)
                s_q[0] <= s_new;
            for (int unsigned k = 1; k < LAT; k++) begin
                vld[k] <= vld[k-1];
                s_q[k] <= s_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ldr_q <= 1'b0;
        else if (accept && mode == MODE_LADDER)
            ldr_q <= kbit;
        else if (ldr_clr)
            ldr_q <= 1'b0;
    end

    generate
        if (LAT == 1) begin : g_s1
            assign s_lane = s_new;
        end else begin : g_sn
            assign s_lane = s_q[LAT-2];
        end

        for (genvar i = 0; i < NLANE; i++) begin : g_lane
            cswap_lane #(
                .WID  (WID),
                .LAT  (LAT),
                .INIT (INIT)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .ld    (accept),
                .s     (s_lane),
                .a     (a[i*WID +: WID]),
                .b     (b[i*WID +: WID]),
                .aswap (aswap[i*WID +: WID]),
                .bswap (bswap[i*WID +: WID])
            );
        end
    endgenerate

    assign out_vld   = vld[LAT-1];
    assign swap_eff  = s_q[LAT-1];
    assign ldr_state = ldr_q;

endmodule

// File: tb/tb_cswap_ladder.sv
module tb_cswap_ladder;

  typedef struct {
    logic [767:0] ea;
    logic [767:0] eb;
    logic         s;
    int           age;
  } beat_t;

  logic         clk, rst;
  logic         in_vld, mode, swap, kbit, ldr_clr, out_rdy;
  logic [767:0] a_bus, b_bus;

  logic [511:0] u0_aw, u0_bw;
  logic [764:0] u1_aw, u1_bw, u2_aw, u2_bw;
  logic         ov [3];
  logic         ir [3];
  logic         se [3];
  logic         ls [3];
  logic [767:0] aw [3];
  logic [767:0] bw [3];

  int    vecs, miscmp;
  beat_t fifo [3][8];
  int    cnt [3];
  int    pops [3];
  int    stalls [3];
  logic  ldr_m [3];
  logic  acc0;

  cswap_ladder #(.WID(256), .NLANE(2), .LAT(2), .INIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(ir[0]), .mode(mode), .swap(swap),
    .kbit(kbit), .ldr_clr(ldr_clr), .a(a_bus[511:0]), .b(b_bus[511:0]), .out_vld(ov[0]),
    .out_rdy(out_rdy), .aswap(u0_aw), .bswap(u0_bw), .swap_eff(se[0]), .ldr_state(ls[0]));

  cswap_ladder #(.WID(255), .NLANE(3), .LAT(1), .INIT(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(ir[1]), .mode(mode), .swap(swap),
    .kbit(kbit), .ldr_clr(ldr_clr), .a(a_bus[764:0]), .b(b_bus[764:0]), .out_vld(ov[1]),
    .out_rdy(out_rdy), .aswap(u1_aw), .bswap(u1_bw), .swap_eff(se[1]), .ldr_state(ls[1]));

  cswap_ladder #(.WID(255), .NLANE(3), .LAT(4), .INIT(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(ir[2]), .mode(mode), .swap(swap),
    .kbit(kbit), .ldr_clr(ldr_clr), .a(a_bus[764:0]), .b(b_bus[764:0]), .out_vld(ov[2]),
    .out_rdy(out_rdy), .aswap(u2_aw), .bswap(u2_bw), .swap_eff(se[2]), .ldr_state(ls[2]));

  assign aw[0] = {256'd0, u0_aw};
  assign bw[0] = {256'd0, u0_bw};
  assign aw[1] = {3'd0, u1_aw};
  assign bw[1] = {3'd0, u1_bw};
  assign aw[2] = {3'd0, u2_aw};
  assign bw[2] = {3'd0, u2_bw};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic fail(input string tag, input int idx, input logic [767:0] obs, input logic [767:0] exp);
    miscmp++;
    $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
  endtask

  function automatic int latf(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 4;
  endfunction

  function automatic logic [767:0] wmask(input int d);
    logic [767:0] m;
    m = '0;
    if (d == 0) m[511:0] = '1;
    else        m[764:0] = '1;
    return m;
  endfunction

  task automatic rand_data();
    for (int unsigned w = 0; w < 24; w++) begin
      a_bus[w*32 +: 32] = $urandom;
      b_bus[w*32 +: 32] = $urandom;
    end
  endtask

  task automatic clear_model();
    for (int unsigned d = 0; d < 3; d++) begin
      cnt[d]   = 0;
      ldr_m[d] = 1'b0;
    end
  endtask

  task automatic cyc();
    logic         eov, eir, s, acc;
    logic [767:0] am, bm;
    @(negedge clk);
    acc0 = 1'b0;
    for (int unsigned d = 0; d < 3; d++) begin
      eov = (cnt[d] > 0) && (fifo[d][0].age == latf(d));
      eir = !(eov && !out_rdy);
      vecs++; if (ov[d] !== eov) fail("out_vld", d, ov[d], eov);
      vecs++; if (ir[d] !== eir) fail("in_rdy", d, ir[d], eir);
      vecs++; if (ls[d] !== ldr_m[d]) fail("ldr_state", d, ls[d], ldr_m[d]);
      if (eov) begin
        vecs++; if (aw[d] !== fifo[d][0].ea) fail("aswap", d, aw[d], fifo[d][0].ea);
        vecs++; if (bw[d] !== fifo[d][0].eb) fail("bswap", d, bw[d], fifo[d][0].eb);
        vecs++; if (se[d] !== fifo[d][0].s) fail("swap_eff", d, se[d], fifo[d][0].s);
      end
      acc = 1'b0;
      if (!eir) stalls[d]++;
      else begin
        if (eov && out_rdy) begin
          for (int unsigned k = 0; k < 7; k++) fifo[d][k] = fifo[d][k+1];
          cnt[d]--;
          pops[d]++;
        end
        for (int k = 0; k < cnt[d]; k++) fifo[d][k].age++;
        acc = in_vld;
        if (acc) begin
          s  = mode ? (kbit ^ (ldr_clr ? 1'b0 : ldr_m[d])) : swap;
          am = a_bus & wmask(d);
          bm = b_bus & wmask(d);
          fifo[d][cnt[d]].ea  = s ? bm : am;
          fifo[d][cnt[d]].eb  = s ? am : bm;
          fifo[d][cnt[d]].s   = s;
          fifo[d][cnt[d]].age = 1;
          cnt[d]++;
        end
      end
      if (acc && mode) ldr_m[d] = kbit;
      else if (ldr_clr) ldr_m[d] = 1'b0;
      if (d == 0) acc0 = acc;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] kseq, ladexp;
    int         sent, p0, st0;
    vecs = 0; miscmp = 0;
    for (int unsigned d = 0; d < 3; d++) begin
      pops[d] = 0;
      stalls[d] = 0;
    end
    clear_model();
    rst = 1'b1; in_vld = 1'b0; mode = 1'b0; swap = 1'b0; kbit = 1'b0;
    ldr_clr = 1'b0; out_rdy = 1'b1; a_bus = '0; b_bus = '0;

    #12;
    for (int unsigned d = 0; d < 3; d++) begin
      vecs++; if (ov[d] !== 1'b0) fail("rst_out_vld", d, ov[d], 1'b0);
      vecs++; if (aw[d] !== 768'd0) fail("rst_aswap", d, aw[d], 768'd0);
      vecs++; if (bw[d] !== 768'd0) fail("rst_bswap", d, bw[d], 768'd0);
      vecs++; if (se[d] !== 1'b0) fail("rst_swap_eff", d, se[d], 1'b0);
      vecs++; if (ir[d] !== 1'b1) fail("rst_in_rdy", d, ir[d], 1'b1);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    a_bus = '0; b_bus = '0;
    a_bus[7:0] = 8'd5; b_bus[7:0] = 8'd9;
    in_vld = 1'b1; swap = 1'b1;
    cyc();
    in_vld = 1'b0;
    cyc();
    vecs++; if (ov[0] !== 1'b1) fail("dir_vld", 0, ov[0], 1'b1);
    vecs++; if (aw[0][255:0] !== 256'd9) fail("dir_a0", 0, aw[0][255:0], 256'd9);
    vecs++; if (bw[0][255:0] !== 256'd5) fail("dir_b0", 0, bw[0][255:0], 256'd5);
    vecs++; if (se[0] !== 1'b1) fail("dir_seff", 0, se[0], 1'b1);
    in_vld = 1'b1; swap = 1'b0;
    cyc();
    in_vld = 1'b0;
    cyc();
    vecs++; if (aw[0][255:0] !== 256'd5) fail("dir_a0_noswap", 0, aw[0][255:0], 256'd5);
    vecs++; if (bw[0][255:0] !== 256'd9) fail("dir_b0_noswap", 0, bw[0][255:0], 256'd9);
    repeat (5) cyc();

    ldr_clr = 1'b1;
    cyc();
    ldr_clr = 1'b0; mode = 1'b1;
    kseq = 5'b01011; ladexp = 5'b11101;
    for (int unsigned j = 0; j < 7; j++) begin
      in_vld = (j < 5);
      kbit = (j < 5) ? kseq[j] : 1'b0;
      rand_data();
      cyc();
      if (j >= 1 && j <= 5) begin
        vecs++; if (ov[0] !== 1'b1) fail("lad_vld", j, ov[0], 1'b1);
        vecs++; if (se[0] !== ladexp[j-1]) fail("lad_seff", j, se[0], ladexp[j-1]);
      end
    end
    vecs++; if (ls[0] !== 1'b0) fail("lad_state_end", 0, ls[0], 1'b0);
    in_vld = 1'b0;
    repeat (5) cyc();

    in_vld = 1'b1; kbit = 1'b1; ldr_clr = 1'b0;
    cyc();
    vecs++; if (ls[0] !== 1'b1) fail("clr_pre", 0, ls[0], 1'b1);
    ldr_clr = 1'b1;
    cyc();
    vecs++; if (ls[0] !== 1'b1) fail("clr_acc", 0, ls[0], 1'b1);
    in_vld = 1'b0;
    cyc();
    ldr_clr = 1'b0;
    vecs++; if (ls[0] !== 1'b0) fail("clr_alone", 0, ls[0], 1'b0);
    repeat (5) cyc();

    mode = 1'b0; sent = 0; p0 = pops[0]; st0 = stalls[0];
    rand_data(); swap = 1'($urandom);
    for (int unsigned c = 0; c < 12; c++) begin
      out_rdy = !(c >= 2 && c <= 4);
      in_vld = (sent < 4);
      cyc();
      if (acc0) begin
        sent++;
        rand_data(); swap = 1'($urandom);
      end
    end
    out_rdy = 1'b1; in_vld = 1'b0;
    repeat (6) cyc();
    vecs++; if ((pops[0] - p0) !== 4) fail("bp_beats_out", 0, pops[0] - p0, 4);
    vecs++; if ((stalls[0] - st0) !== 3) fail("bp_stall_cycles", 0, stalls[0] - st0, 3);

    mode = 1'b1; kbit = 1'b1; in_vld = 1'b1;
    cyc();
    rand_data();
    cyc();
    in_vld = 1'b0;
    vecs++; if (ov[0] !== 1'b1) fail("pre_rst_vld", 0, ov[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    for (int unsigned d = 0; d < 3; d++) begin
      vecs++; if (ov[d] !== 1'b0) fail("arst_out_vld", d, ov[d], 1'b0);
      vecs++; if (aw[d] !== 768'd0) fail("arst_aswap", d, aw[d], 768'd0);
      vecs++; if (ls[d] !== 1'b0) fail("arst_ldr", d, ls[d], 1'b0);
    end
    clear_model();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    mode = 1'b0; swap = 1'b1; in_vld = 1'b1;
    rand_data();
    cyc();
    in_vld = 1'b0;
    vecs++; if (ov[0] !== 1'b0) fail("post_rst_lat1", 0, ov[0], 1'b0);
    cyc();
    vecs++; if (ov[0] !== 1'b1) fail("post_rst_lat2", 0, ov[0], 1'b1);
    repeat (5) cyc();

    for (int unsigned c = 0; c < 400; c++) begin
      rand_data();
      in_vld  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      mode    = 1'($urandom);
      swap    = 1'($urandom);
      kbit    = 1'($urandom);
      ldr_clr = ($urandom_range(0, 7) == 0);
      cyc();
    end
    in_vld = 1'b0; out_rdy = 1'b1; ldr_clr = 1'b0;
    repeat (8) cyc();
    for (int unsigned d = 0; d < 3; d++) begin
      vecs++; if (cnt[d] !== 0) fail("drain_empty", d, cnt[d], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
